// File: rtl/simon_sequence_player.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// simon_sequence_player
//
// Purpose:
//   Presents the Simon Says button sequence on the LED outputs. A 16-bit
//   Fibonacci LFSR (restarted from SEED on every playback) produces one 2-bit
//   symbol per step. Each symbol is lit for ON_CYCLES cycles and followed by
//   a dark gap of OFF_CYCLES cycles. A one-cycle done pulse ends a complete
//   playback. The downstream checker regenerates the same sequence with its
//   own LFSR copy, so SEED and the no-repeat setting must match there.
//
// Handshake:
//   start is a one-cycle request that is honoured only in IDLE (busy low).
//   A start seen while busy is dropped, not queued. abort beats every other
//   input and returns the block to IDLE on the next edge without a done.
//
// Optional feature (compile-time macro SIMON_NO_REPEAT_EN):
//   When defined, a raw symbol equal to the previously emitted symbol is
//   replaced by (raw+1) mod 4. The first symbol of a playback is never altered.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   start      in   begin a playback (IDLE only)
//   abort      in   stop playback immediately, no done
//   level[5:0] in   symbols to play, sampled with start, clipped to MAX_LEN
//   led_sym    out  current symbol (button 0..3)
//   led_valid  out  high while a symbol is shown
//   sym_index  out  0-based index of the current or last symbol
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse after the last gap
// -----------------------------------------------------------------------------
module simon_sequence_player #(
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          MAX_LEN    = 32,
    parameter int          ON_CYCLES  = 4,
    parameter int          OFF_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [5:0] level,
    output logic [1:0] led_sym,
    output logic       led_valid,
    output logic [5:0] sym_index,
    output logic       busy,
    output logic       done
);

    // Dwell counter counts down from (cycles-1) to 0, so it only has to hold
    // max(ON_CYCLES, OFF_CYCLES)-1 and can never wrap.
    localparam int DWELL_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CW        = (DWELL_MAX > 1) ? $clog2(DWELL_MAX) : 1;

    localparam logic [CW-1:0] ON_LOAD   = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LOAD  = CW'(OFF_CYCLES - 1);
    localparam logic [5:0]    MAX_LEN_W = 6'(MAX_LEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Taps 16,14,13,11 expressed on the right-shifting register.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    state_t          state_q;
    logic [15:0]     lfsr_q;
    logic [CW-1:0]   cnt_q;
    logic [5:0]      len_q;
    logic [1:0]      led_sym_q;
    logic            led_valid_q;
    logic [5:0]      sym_index_q;
    logic            busy_q;
    logic            done_q;

    logic [5:0]      len_d;
    logic [1:0]      raw_sym;
    logic [1:0]      next_sym_d;
    logic            last_sym;

    always_comb begin
        len_d    = (level > MAX_LEN_W) ? MAX_LEN_W : level;
        raw_sym  = lfsr_q[1:0];
        last_sym = (sym_index_q == (len_q - 6'd1));
`ifdef SIMON_NO_REPEAT_EN
        // led_sym_q still holds the previously emitted symbol during OFF.
        next_sym_d = (raw_sym == led_sym_q) ? (raw_sym + 2'd1) : raw_sym;
`else
        next_sym_d = raw_sym;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= SEED;
            cnt_q       <= '0;
            len_q       <= '0;
            led_sym_q   <= '0;
            led_valid_q <= 1'b0;
            sym_index_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (abort) begin
            // sym_index and led_sym are left as they were.
            state_q     <= ST_IDLE;
            led_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        len_q       <= len_d;
                        sym_index_q <= '0;
                        busy_q      <= 1'b1;
                        if (len_d == 6'd0) begin
                            lfsr_q  <= SEED;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            // Load SEED and take the first symbol from it in
                            // the same edge; the LFSR advances once on entry.
                            led_sym_q   <= SEED[1:0];
                            led_valid_q <= 1'b1;
                            lfsr_q      <= lfsr_step(SEED);
                            cnt_q       <= ON_LOAD;
                            state_q     <= ST_ON;
                        end
                    end
                end
                ST_ON: begin
                    if (cnt_q == '0) begin
                        led_valid_q <= 1'b0;
                        cnt_q       <= OFF_LOAD;
                        state_q     <= ST_OFF;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_OFF: begin
                    if (cnt_q == '0) begin
                        if (last_sym) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            sym_index_q <= sym_index_q + 6'd1;
                            led_sym_q   <= next_sym_d;
                            led_valid_q <= 1'b1;
                            lfsr_q      <= lfsr_step(lfsr_q);
                            cnt_q       <= ON_LOAD;
                            state_q     <= ST_ON;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    led_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign led_sym   = led_sym_q;
    assign led_valid = led_valid_q;
    assign sym_index = sym_index_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_simon_sequence_player.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_simon_sequence_player
//
// Drives playbacks of simon_sequence_player with default parameters. The bench
// owns a reference LFSR that fills the expected-symbol queue when a start is
// driven; a negedge monitor pops and compares each symbol when led_valid rises
// and checks the lit duration. Driver tasks check done latency, final index,
// abort behaviour and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_simon_sequence_player;

    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          MAX_LEN = 32;
    localparam int          ON_C    = 4;
    localparam int          OFF_C   = 2;
    localparam int          BUDGET  = 400;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [5:0] level;
    logic [1:0] led_sym;
    logic       led_valid;
    logic [5:0] sym_index;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    simon_sequence_player #(
        .SEED       (SEED),
        .MAX_LEN    (MAX_LEN),
        .ON_CYCLES  (ON_C),
        .OFF_CYCLES (OFF_C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .level     (level),
        .led_sym   (led_sym),
        .led_valid (led_valid),
        .sym_index (sym_index),
        .busy      (busy),
        .done      (done)
    );

    // ---------------- scoreboard ----------------
    logic [1:0] exp_q[$];
    logic [1:0] got_log[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         done_cnt = 0;
    int         skip_req = 0;
    int         skip_ack = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_step(input logic [15:0] l);
        logic fb;
        fb = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {fb, l[15:1]};
    endfunction

    // Fill the expected queue with the first n symbols of a playback.
    task automatic push_model(input int n);
        logic [15:0] l;
        logic [1:0]  raw;
        logic [1:0]  sym;
        logic [1:0]  prev;
        l    = SEED;
        prev = 2'd0;
        for (int i = 0; i < n; i++) begin
            raw = l[1:0];
            sym = raw;
`ifdef SIMON_NO_REPEAT_EN
            if (i > 0 && raw == prev) sym = raw + 2'd1;
`endif
            exp_q.push_back(sym);
            prev = sym;
            l = ref_step(l);
        end
    endtask

    // ---------------- monitor ----------------
    logic prev_valid = 1'b0;
    int   run_len = 0;

    always @(negedge clk) begin
        if (led_valid && !prev_valid) begin
            run_len = 1;
            got_log.push_back(led_sym);
            if (exp_q.size() > 0) check_val("sym", 32'(led_sym), 32'(exp_q.pop_front()));
        end else if (led_valid) begin
            run_len++;
        end else if (prev_valid) begin
            if (skip_req == skip_ack) check_val("on_len", run_len, ON_C);
            skip_ack = skip_req;
        end
        if (done) done_cnt++;
        prev_valid = led_valid;
    end

    // ---------------- driver tasks ----------------
    // Full playback; if inj_n > 0 a stray start is pulsed in that cycle.
    task automatic play_full(input int lvl, input int inj_n);
        int exp_len;
        int n;
        int base;
        bit seen;
        exp_len = (lvl > MAX_LEN) ? MAX_LEN : lvl;
        base    = got_log.size();
        push_model(exp_len);
        @(negedge clk);
        level = 6'(lvl);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n    = 1;
        seen = 1'b0;
        while (n <= BUDGET && !seen) begin
            if (n == 1) check_val("busy_rise", busy, 1);
            if (done) begin
                seen = 1'b1;
            end else begin
                if (n == inj_n) begin
                    start = 1'b1;
                    level = 6'd1;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
        check_val("done_seen", seen, 1);
        if (seen) check_val("done_lat", n, (ON_C + OFF_C) * exp_len + 1);
        check_val("last_index", sym_index, (exp_len == 0) ? 0 : exp_len - 1);
        check_val("sym_count", got_log.size() - base, exp_len);
        check_val("exp_left", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        check_val("done_width", done, 0);
        check_val("busy_fall", busy, 0);
    endtask

    // Playback aborted at cycle ab_n after start.
    task automatic play_abort(input int lvl, input int ab_n, input int exp_idx, input int exp_syms);
        int n;
        int base;
        int d0;
        base = got_log.size();
        push_model(lvl);
        @(negedge clk);
        level = 6'(lvl);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n < ab_n) begin
            @(negedge clk);
            n++;
        end
        skip_req++;
        d0    = done_cnt;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("abort_busy", busy, 0);
        check_val("abort_valid", led_valid, 0);
        check_val("abort_index", sym_index, exp_idx);
        check_val("abort_syms", got_log.size() - base, exp_syms);
        exp_q.delete();
        repeat (12) @(negedge clk);
        check_val("abort_no_done", done_cnt - d0, 0);
        check_val("abort_idle", busy, 0);
    endtask

    task automatic reset_mid_on();
        @(negedge clk);
        level = 6'd4;
        start = 1'b1;
        push_model(4);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        skip_req++;
        rst = 1'b1;
        #1;
        check_val("rst_led_sym", led_sym, 0);
        check_val("rst_led_valid", led_valid, 0);
        check_val("rst_sym_index", sym_index, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_idle_busy", busy, 0);
    endtask

    // ---------------- main ----------------
    initial begin
        int b;
        int b1;
        int b2;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        level = 6'd0;
        repeat (3) @(negedge clk);
        check_val("reset_led_sym", led_sym, 0);
        check_val("reset_led_valid", led_valid, 0);
        check_val("reset_sym_index", sym_index, 0);
        check_val("reset_busy", busy, 0);
        check_val("reset_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic playback of four symbols.
        b = got_log.size();
        play_full(4, 0);
        if (got_log.size() > b) check_val("basic_first", got_log[b], 1);

        // Zero length and clipped length.
        play_full(0, 0);
        play_full(63, 0);

        // Stray start while showing symbol 2 is dropped.
        play_full(4, 8);

        // Abort while showing symbol 2, then a fresh playback.
        play_abort(4, 8, 1, 2);
        play_full(4, 0);

        // Asynchronous reset while a symbol is lit, then normal play.
        reset_mid_on();
        play_full(4, 0);

        // Back-to-back playbacks must be identical.
        b1 = got_log.size();
        play_full(8, 0);
        b2 = got_log.size();
        play_full(8, 0);
        if (got_log.size() - b2 == 8 && b2 - b1 == 8) begin
            for (int i = 0; i < 8; i++) check_val("replay", got_log[b2 + i], got_log[b1 + i]);
        end else begin
            check_val("replay_len", got_log.size() - b2, b2 - b1);
        end

        // Random level values against the model.
        for (int k = 0; k < 3; k++) play_full($urandom_range(1, 10), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/simon_sequence_player.md
# simon_sequence_player

Sequence presenter for the Simon Says game. It generates the reproducible pseudo-random button sequence and plays it out on the LED outputs, one symbol at a time, with fixed on and off times. It sits upstream of the player-input checker, which samples `knapp_comb` and drives `correct_out`/`count_out`. Because the sequence restarts from the seed on every playback, the checker regenerates the identical sequence with its own copy of the LFSR.

## Interface
Parameters:
- `SEED`, 16'hACE1: LFSR value loaded at each `start`; must be nonzero.
- `MAX_LEN`, 32: maximum symbols per playback (1..63).
- `ON_CYCLES`, 4: cycles each symbol is shown (≥1).
- `OFF_CYCLES`, 2: dark gap after each symbol (≥1).

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-high reset.
- `start` in 1: one-cycle request to begin a playback; honoured only in IDLE.
- `abort` in 1: stops playback immediately; no `done`.
- `level` in 6: number of symbols to play; sampled with `start`.
- `led_sym` out 2: current symbol (button 0..3).
- `led_valid` out 1: high while a symbol is shown.
- `sym_index` out 6: index of the current or last symbol, 0-based.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last gap.

## Operation
- States: IDLE, ON, OFF, DONE.
- **Reset values:** `led_sym`=0, `led_valid`=0, `sym_index`=0, `busy`=0, `done`=0. State=IDLE, LFSR=`SEED`.
- **IDLE + `start`:**
  - Latch `len` = min(`level`, `MAX_LEN`), load LFSR=`SEED`, clear `sym_index`.
  - If `len`=0, go to DONE.
  - Otherwise go to ON with the first symbol.
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11.
  - Feedback bit = l[0]^l[2]^l[3]^l[5].
  - Next value = {fb, l[15:1]}.
  - Raw symbol = l[1:0], read before the advance.
  - The LFSR advances exactly once per symbol, on entry to ON.
- **ON:** `led_valid`=1 and `led_sym` is held for `ON_CYCLES` cycles, then go to OFF.
- **OFF:** `led_valid`=0 for `OFF_CYCLES` cycles. `led_sym` keeps its last value.
  - If `sym_index`=`len`-1, go to DONE.
  - Otherwise increment `sym_index` and go to ON.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **`start` while `busy`:** ignored; not queued.
- **`abort`:** wins over all other inputs in any state. On the next edge: IDLE, `led_valid`=0, no `done` pulse. `sym_index` holds its value.
- **`start` and `abort` in the same cycle in IDLE:** `abort` wins; the block stays in IDLE.
- **`rst` mid-playback:** all outputs return to their reset values asynchronously. No `done` pulse.
- **Dwell counter:** wide enough for max(`ON_CYCLES`, `OFF_CYCLES`); it never wraps.

## Timing
- `start` sampled at edge T:
  - `led_valid` is high from T+1 through T+`ON_CYCLES`.
  - The next symbol appears at T+1+`ON_CYCLES`+`OFF_CYCLES`.
- **Playback length:** `len`·(`ON_CYCLES`+`OFF_CYCLES`) cycles. `done` is high in the following cycle; IDLE follows one cycle later.
- **`len`=0:** `done` at T+1.
- **Registered outputs:** all outputs are registered. `busy` rises at T+1 and falls in the cycle after `done`.
- **Restart:** the earliest accepted restart is the cycle in which `busy` is low again.

## Configuration
- **`SIMON_NO_REPEAT_EN` defined:** if the raw symbol equals the previously emitted symbol, emit (raw+1) mod 4. The first symbol is never altered. The checker must be built with the same setting.
- **Not defined:** the raw symbol is emitted unchanged.

## Test plan
- **Reset:** assert `rst` mid-ON. → All outputs go to 0 immediately; state is IDLE after release.
- **Basic playback:** defaults, `level`=4, `start` pulse, macro off. → `led_sym` sequence 1,0,0,0. Each symbol shows 4 cycles `led_valid` high, then 2 low. `done` one cycle after 24 playback cycles; `sym_index` ends at 3.
- **No-repeat:** same stimulus with `SIMON_NO_REPEAT_EN` defined. → Sequence 1,0,1,0.
- **Edge lengths:** `level`=0. → `done` at T+1 and no `led_valid`. `level`=63 with `MAX_LEN`=32. → Exactly 32 symbols.
- **Ignored start / abort:** `start` pulse during symbol 2. → Ignored; the sequence is unchanged. `abort` during symbol 2. → IDLE next cycle, no `done`. A following `start` replays from 1,0,0,0.
- **Replay determinism:** two back-to-back playbacks with `level`=8. → Identical symbol sequences.
